// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: phase sequencer for the snake game. It issues the movement step and
// commits the player's direction. It also paces steps by tail length and generates the
// datapath restart pulse.
// Latency: update_tick rises one cycle after the frame_start that completes a step period.
// Backpressure: none. All inputs are one-cycle pulses or levels sampled every cycle, and
// nothing is queued.
//
// Ports:
//   vga_clk, reset          clock; asynchronous active-high reset
//   frame_start             one pulse per video frame
//   btn_start, btn_pause    debounced one-cycle button pulses
//   dir_valid, dir_req      direction request strobe and value (0 L, 1 T, 2 R, 3 D)
//   game_over, game_won     collision and win levels from the datapath
//   tail_count              current tail length, used to pick the speed level
//   update_tick             one-cycle step enable to the datapath
//   direction               committed direction
//   logic_reset             synchronous restart to the datapath
//   phase                   0 IDLE, 1 RESTART, 2 PLAY, 3 PAUSE, 4 OVER, 5 WON
//   speed_level             current speed level
module game_flow_ctrl #(
    parameter int BASE_FRAMES     = 8,
    parameter int MIN_FRAMES      = 2,
    parameter int TAILS_PER_LEVEL = 4,
    parameter int TAIL_W          = 6,
    parameter int RESET_CYCLES    = 2
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              btn_start,
    input  logic              btn_pause,
    input  logic              dir_valid,
    input  logic [1:0]        dir_req,
    input  logic              game_over,
    input  logic              game_won,
    input  logic [TAIL_W-1:0] tail_count,
    output logic              update_tick,
    output logic [1:0]        direction,
    output logic              logic_reset,
    output logic [2:0]        phase,
    output logic [3:0]        speed_level
);

    localparam logic [2:0] PH_IDLE    = 3'd0;
    localparam logic [2:0] PH_RESTART = 3'd1;
    localparam logic [2:0] PH_PLAY    = 3'd2;
    localparam logic [2:0] PH_PAUSE   = 3'd3;
    localparam logic [2:0] PH_OVER    = 3'd4;
    localparam logic [2:0] PH_WON     = 3'd5;

    localparam logic [1:0] DIR_RIGHT  = 2'd2;

    localparam int MAX_LEVEL = BASE_FRAMES - MIN_FRAMES;
    localparam int CNT_W     = $clog2(BASE_FRAMES + 1);
    localparam int RST_W     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    logic [2:0]        phase_q,   phase_d;
    logic [1:0]        dir_q,     dir_d;
    logic [1:0]        pend_q,    pend_d;
    logic [CNT_W-1:0]  frm_cnt_q, frm_cnt_d;
    logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic              tick_q,    tick_d;
    logic [3:0]        speed_q,   speed_d;

    logic [TAIL_W-1:0] lvl_raw;
    logic [CNT_W-1:0]  period;
    logic [CNT_W:0]    cnt_inc;
    logic              period_done;

    // The speed level saturates so that the step period never drops below MIN_FRAMES.
    assign lvl_raw = tail_count / TAIL_W'(TAILS_PER_LEVEL);
    assign speed_d = (int'(lvl_raw) > MAX_LEVEL) ? 4'(MAX_LEVEL) : 4'(lvl_raw);

    always_comb begin
        if (int'(speed_q) > MAX_LEVEL) begin
            period = CNT_W'(MIN_FRAMES);
        end else begin
            period = CNT_W'(BASE_FRAMES - int'(speed_q));
        end
    end

    // The compare uses >= instead of ==. When the period shrinks below the frame count
    // already reached, the next frame_start still ends the step.
    assign cnt_inc     = {1'b0, frm_cnt_q} + (CNT_W+1)'(1);
    assign period_done = (cnt_inc >= {1'b0, period});

    always_comb begin
        phase_d   = phase_q;
        dir_d     = dir_q;
        pend_d    = pend_q;
        frm_cnt_d = frm_cnt_q;
        rst_cnt_d = rst_cnt_q;
        tick_d    = 1'b0;

        case (phase_q)
            PH_IDLE: begin
                if (btn_start) begin
                    phase_d   = PH_RESTART;
                    rst_cnt_d = '0;
                end
            end

            PH_RESTART: begin
                dir_d     = DIR_RIGHT;
                pend_d    = DIR_RIGHT;
                frm_cnt_d = '0;
                if (rst_cnt_q == RST_W'(RESET_CYCLES - 1)) begin
                    phase_d   = PH_PLAY;
                    rst_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end

            PH_PLAY: begin
                // A reversal is judged against the committed direction, not the pending one.
                if (dir_valid && (dir_req != (dir_q ^ 2'b10))) begin
                    pend_d = dir_req;
                end
                if (game_won) begin
                    phase_d = PH_WON;
                end else if (game_over) begin
                    phase_d = PH_OVER;
                end else if (btn_pause) begin
                    phase_d = PH_PAUSE;
                end else if (frame_start) begin
                    if (period_done) begin
                        frm_cnt_d = '0;
                        tick_d    = 1'b1;
                        // The old pending value is committed together with the tick. A
                        // request arriving now only updates pending for the next step.
                        dir_d     = pend_q;
                    end else begin
                        frm_cnt_d = cnt_inc[CNT_W-1:0];
                    end
                end
            end

            PH_PAUSE: begin
                if (btn_start) begin
                    phase_d   = PH_RESTART;
                    rst_cnt_d = '0;
                end else if (btn_pause) begin
                    phase_d = PH_PLAY;
                end
            end

            PH_OVER, PH_WON: begin
                if (btn_start) begin
                    phase_d   = PH_RESTART;
                    rst_cnt_d = '0;
                end
            end

            default: begin
                phase_d = PH_IDLE;
            end
        endcase
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            phase_q   <= PH_IDLE;
            dir_q     <= DIR_RIGHT;
            pend_q    <= DIR_RIGHT;
            frm_cnt_q <= '0;
            rst_cnt_q <= '0;
            tick_q    <= 1'b0;
            speed_q   <= 4'd0;
        end else begin
            phase_q   <= phase_d;
            dir_q     <= dir_d;
            pend_q    <= pend_d;
            frm_cnt_q <= frm_cnt_d;
            rst_cnt_q <= rst_cnt_d;
            tick_q    <= tick_d;
            speed_q   <= speed_d;
        end
    end

    assign update_tick = tick_q;
    assign direction   = dir_q;
    // This output is decoded from the registered phase, so it drops on the first PLAY
    // cycle and falls immediately when reset is asserted.
    assign logic_reset = (phase_q == PH_RESTART);
    assign phase       = phase_q;
    assign speed_level = speed_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: drives directed and random traffic into game_flow_ctrl. Every cycle
// it compares the outputs against a reference model built from the game rules.
// Latency: outputs are compared at the negedge that follows each rising edge.
// Backpressure: not applicable.
module tb_game_flow_ctrl;

    localparam int BASE_FRAMES     = 8;
    localparam int MIN_FRAMES      = 2;
    localparam int TAILS_PER_LEVEL = 4;
    localparam int TAIL_W          = 6;
    localparam int RESET_CYCLES    = 2;

    logic              vga_clk = 1'b0;
    logic              reset   = 1'b1;
    logic              frame_start = 1'b0;
    logic              btn_start   = 1'b0;
    logic              btn_pause   = 1'b0;
    logic              dir_valid   = 1'b0;
    logic [1:0]        dir_req     = 2'd0;
    logic              game_over   = 1'b0;
    logic              game_won    = 1'b0;
    logic [TAIL_W-1:0] tail_count  = '0;
    logic              update_tick;
    logic [1:0]        direction;
    logic              logic_reset;
    logic [2:0]        phase;
    logic [3:0]        speed_level;

    always #5 vga_clk = ~vga_clk;

    game_flow_ctrl #(
        .BASE_FRAMES     (BASE_FRAMES),
        .MIN_FRAMES      (MIN_FRAMES),
        .TAILS_PER_LEVEL (TAILS_PER_LEVEL),
        .TAIL_W          (TAIL_W),
        .RESET_CYCLES    (RESET_CYCLES)
    ) dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .frame_start (frame_start),
        .btn_start   (btn_start),
        .btn_pause   (btn_pause),
        .dir_valid   (dir_valid),
        .dir_req     (dir_req),
        .game_over   (game_over),
        .game_won    (game_won),
        .tail_count  (tail_count),
        .update_tick (update_tick),
        .direction   (direction),
        .logic_reset (logic_reset),
        .phase       (phase),
        .speed_level (speed_level)
    );

    int n_total = 0;
    int n_bad   = 0;
    int tick_seen = 0;
    int lr_seen   = 0;

    // Reference model. Phases are 0 idle, 1 restart, 2 play, 3 pause, 4 over, 5 won.
    int m_phase, m_dir, m_pend, m_frames, m_rst_left, m_speed, m_tick;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int period_of(input int lvl);
        int p;
        p = BASE_FRAMES - lvl;
        return (p < MIN_FRAMES) ? MIN_FRAMES : p;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_dir = 2; m_pend = 2; m_frames = 0;
        m_rst_left = 0; m_speed = 0; m_tick = 0;
    endtask

    task automatic model_step();
        int new_speed, np, nt;
        new_speed = int'(tail_count) / TAILS_PER_LEVEL;
        if (new_speed > BASE_FRAMES - MIN_FRAMES) new_speed = BASE_FRAMES - MIN_FRAMES;
        nt = 0;
        case (m_phase)
            0: if (btn_start) begin m_phase = 1; m_rst_left = RESET_CYCLES; end
            1: begin
                m_dir = 2; m_pend = 2; m_frames = 0;
                m_rst_left--;
                if (m_rst_left == 0) m_phase = 2;
            end
            2: begin
                np = m_pend;
                if (dir_valid && (int'(dir_req) != (m_dir ^ 2))) np = int'(dir_req);
                if (game_won)       m_phase = 5;
                else if (game_over) m_phase = 4;
                else if (btn_pause) m_phase = 3;
                else if (frame_start) begin
                    m_frames++;
                    if (m_frames >= period_of(m_speed)) begin
                        m_frames = 0;
                        nt = 1;
                        m_dir = m_pend;
                    end
                end
                m_pend = np;
            end
            3: begin
                if (btn_start) begin m_phase = 1; m_rst_left = RESET_CYCLES; end
                else if (btn_pause) m_phase = 2;
            end
            default: if (btn_start) begin m_phase = 1; m_rst_left = RESET_CYCLES; end
        endcase
        m_tick  = nt;
        m_speed = new_speed;
    endtask

    task automatic check_outputs();
        chk("phase",  int'(phase),       m_phase);
        chk("tick",   int'(update_tick), m_tick);
        chk("dir",    int'(direction),   m_dir);
        chk("lreset", int'(logic_reset), (m_phase == 1) ? 1 : 0);
        chk("speed",  int'(speed_level), m_speed);
    endtask

    // Inputs are already applied at a negedge when this task is called. It returns at the
    // next negedge after the outputs have been checked.
    task automatic run_cycle();
        model_step();
        @(posedge vga_clk);
        @(negedge vga_clk);
        check_outputs();
        if (update_tick) tick_seen++;
        if (logic_reset) lr_seen++;
    endtask

    task automatic clear_inputs();
        frame_start = 1'b0; btn_start = 1'b0; btn_pause = 1'b0;
        dir_valid = 1'b0; dir_req = 2'd0; game_over = 1'b0; game_won = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1; run_cycle();
            frame_start = 1'b0; run_cycle();
        end
    endtask

    task automatic start_game();
        btn_start = 1'b1; run_cycle();
        btn_start = 1'b0;
        repeat (RESET_CYCLES + 1) run_cycle();
    endtask

    task automatic async_reset();
        reset = 1'b1;
        #1;
        model_reset();
        chk("areset_phase",  int'(phase),       0);
        chk("areset_lreset", int'(logic_reset), 0);
        chk("areset_tick",   int'(update_tick), 0);
        chk("areset_dir",    int'(direction),   2);
        @(posedge vga_clk);
        @(negedge vga_clk);
        reset = 1'b0;
        check_outputs();
    endtask

    initial begin
        int n;
        bit hit;
        clear_inputs();
        model_reset();
        repeat (3) @(negedge vga_clk);
        check_outputs();
        reset = 1'b0;

        // Restart sequence: logic_reset is held for RESET_CYCLES cycles, then PLAY begins.
        lr_seen = 0;
        start_game();
        chk("restart_len", lr_seen, RESET_CYCLES);
        chk("play_after_restart", int'(phase), 2);
        chk("dir_after_restart", int'(direction), 2);

        // 16 frames at speed level 0 give two steps.
        tick_seen = 0;
        frames(16);
        chk("ticks_16_frames", tick_seen, 2);

        // Reversal is dropped, and the last valid request wins.
        dir_valid = 1'b1; dir_req = 2'd0; run_cycle();
        dir_valid = 1'b0;
        frames(8);
        chk("reversal_dropped", int'(direction), 2);
        dir_valid = 1'b1; dir_req = 2'd1; run_cycle();
        dir_req = 2'd3; run_cycle();
        dir_valid = 1'b0;
        frames(8);
        chk("last_req_wins", int'(direction), 3);

        // Speed scaling and saturation.
        tail_count = 6'd25; run_cycle();
        chk("speed_25", int'(speed_level), 6);
        tail_count = 6'd40; run_cycle();
        chk("speed_40_sat", int'(speed_level), 6);
        tick_seen = 0;
        frames(4);
        chk("fast_ticks", tick_seen, 2);
        tail_count = 6'd9; run_cycle();
        chk("speed_9", int'(speed_level), 2);

        // Pause freezes the frame count.
        tail_count = '0; run_cycle(); run_cycle();
        game_over = 1'b1; run_cycle();
        game_over = 1'b0;
        chk("over_phase", int'(phase), 4);
        start_game();
        frames(3);
        btn_pause = 1'b1; run_cycle(); btn_pause = 1'b0;
        chk("paused", int'(phase), 3);
        tick_seen = 0;
        frames(10);
        chk("no_ticks_paused", tick_seen, 0);
        btn_pause = 1'b1; run_cycle(); btn_pause = 1'b0;
        chk("resumed", int'(phase), 2);
        n = 0; hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            frame_start = 1'b1; run_cycle(); n++;
            hit = update_tick;
            frame_start = 1'b0; run_cycle();
        end
        chk("frames_to_tick_after_pause", n, 5);

        // A win and an over arriving together with a due step: win wins, and no tick is issued.
        frames(7);
        frame_start = 1'b1; game_over = 1'b1; game_won = 1'b1; run_cycle();
        chk("won_priority", int'(phase), 5);
        chk("no_tick_on_exit", int'(update_tick), 0);
        clear_inputs(); run_cycle();
        chk("won_holds", int'(phase), 5);
        btn_start = 1'b1; run_cycle(); btn_start = 1'b0;
        chk("won_restart", int'(phase), 1);
        chk("won_restart_lreset", int'(logic_reset), 1);

        // Asynchronous reset while in restart, then while a tick is high.
        async_reset();
        start_game();
        frames(7);
        frame_start = 1'b1; run_cycle(); frame_start = 1'b0;
        chk("tick_before_reset", int'(update_tick), 1);
        async_reset();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            frame_start = ($urandom_range(3) == 0);
            btn_start   = ($urandom_range(49) == 0);
            btn_pause   = ($urandom_range(39) == 0);
            dir_valid   = ($urandom_range(2) == 0);
            dir_req     = 2'($urandom_range(3));
            game_over   = ($urandom_range(149) == 0);
            game_won    = ($urandom_range(299) == 0);
            if ($urandom_range(99) == 0) tail_count = TAIL_W'($urandom_range(63));
            run_cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
